// File: rtl/uart_tx_block.sv
// 8N1 UART transmitter that ships a captured 64-bit CAN payload as BYTES bytes,
// most significant byte first, each byte LSB first.
module uart_tx_block #(
  parameter int CLKS_PER_BIT = 868,
  parameter int BYTES        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  uart_start,
  input  logic [63:0] rx_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BYTE_LAST = 3'(BYTES - 1);
  localparam logic [1:0]  REQ_SEND  = 2'b01;

  state_t      state_r, state_s;
  logic [15:0] baud_r, baud_s;
  logic [2:0]  bit_r, bit_s;
  logic [2:0]  byte_r, byte_s;
  logic [63:0] shadow_r, shadow_s;
  logic [1:0]  start_prev_r;
  logic        trigger_s;
  logic        baud_end_s;
  logic        tx_s;
  logic        busy_s;
  logic        done_s;
  logic        overrun_s;

  // Line level for a given state; byte k bit b lives at shadow[8*(7-k) + b],
  // and 7-k is simply the bitwise inverse of a 3-bit k.
  function automatic logic line_bit(input state_t st, input logic [63:0] sh,
                                    input logic [2:0] byte_idx, input logic [2:0] bit_idx);
    logic v;
    case (st)
      IDLE:    v = 1'b1;
      START:   v = 1'b0;
      DATA:    v = sh[{~byte_idx, bit_idx}];
      STOP:    v = 1'b1;
      default: v = 1'b1;
    endcase
    return v;
  endfunction

  assign trigger_s  = (uart_start == REQ_SEND) && (start_prev_r != REQ_SEND);
  assign baud_end_s = (baud_r == BAUD_LAST);

  // Next-state and counter logic for the frame sequencer
  always_comb begin
    state_s  = state_r;
    baud_s   = baud_r;
    bit_s    = bit_r;
    byte_s   = byte_r;
    shadow_s = shadow_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          state_s  = START;
          shadow_s = rx_data;
          baud_s   = 16'd0;
          bit_s    = 3'd0;
          byte_s   = 3'd0;
        end else begin
          baud_s = 16'd0;
        end
      end
      START: begin
        if (baud_end_s) begin
          state_s = DATA;
          baud_s  = 16'd0;
          bit_s   = 3'd0;
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s = 16'd0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
            bit_s   = 3'd0;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_s = 16'd0;
          if (byte_r == BYTE_LAST) begin
            state_s = IDLE;
            byte_s  = 3'd0;
            done_s  = 1'b1;
          end else begin
            state_s = START;
            byte_s  = byte_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = 16'd0;
        bit_s   = 3'd0;
        byte_s  = 3'd0;
      end
    endcase
  end

  // Overrun is sticky across the frame and cleared only by an accepted trigger
  always_comb begin
    overrun_s = overrun;
    if (!trigger_s) begin
      overrun_s = overrun;
    end else if (state_r == IDLE) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    tx_s   = line_bit(state_s, shadow_s, byte_s, bit_s);
    busy_s = (state_s != IDLE);
  end

  // State, counters, shadow and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      baud_r       <= 16'd0;
      bit_r        <= 3'd0;
      byte_r       <= 3'd0;
      shadow_r     <= 64'd0;
      start_prev_r <= 2'b00;
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      bit_r        <= bit_s;
      byte_r       <= byte_s;
      shadow_r     <= shadow_s;
      start_prev_r <= uart_start;
      uart_tx      <= tx_s;
      busy         <= busy_s;
      done         <= done_s;
      overrun      <= overrun_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block with CLKS_PER_BIT=4, BYTES=8: cycle vectors
// for reset/trigger behaviour plus frame-level sequences decoded from the line.
module tb_uart_tx_block;

  logic        clk;
  logic        rst;
  logic [1:0]  uart_start;
  logic [63:0] rx_data;
  logic        uart_tx;
  logic        busy;
  logic        done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  uart_tx_block #(.CLKS_PER_BIT(4), .BYTES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_start (uart_start),
    .rx_data    (rx_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] start;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ov;
  } cyc_vec_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp_bytes;
    logic [0:9]  exp_line0;
  } frame_vec_t;

  cyc_vec_t   cv[13];
  frame_vec_t fv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call in the first START cycle of a frame; returns in the done cycle.
  task automatic run_frame(input string name, input logic [63:0] exp_bytes,
                           input logic [0:9] exp_line0, input int release_at,
                           input int inj_at, input logic exp_ov);
    logic        tx_samp [320];
    logic [0:79] line_v;
    logic [63:0] got;
    logic [7:0]  b;
    logic        ok;
    int          busy_n;
    ok = 1'b1;
    busy_n = 0;
    chk({name, " overrun at start"}, 64'(overrun), 64'd0);
    for (int c = 0; c < 320; c++) begin
      tx_samp[c] = uart_tx;
      if (busy) busy_n++;
      if (done) ok = 1'b0;
      if (c == release_at) uart_start = 2'b00;
      if (c == inj_at) begin
        uart_start = 2'b01;
        rx_data = '1;
      end
      if (inj_at >= 0 && c == inj_at + 1) uart_start = 2'b00;
      tick();
    end
    chk({name, " busy cycles"}, 64'(busy_n), 64'd320);
    chk({name, " end busy/done"}, 64'({busy, done}), 64'd1);
    chk({name, " overrun at end"}, 64'(overrun), 64'(exp_ov));
    for (int s = 0; s < 80; s++) begin
      line_v[s] = tx_samp[s*4];
      for (int k = 1; k < 4; k++)
        if (tx_samp[s*4+k] !== line_v[s]) ok = 1'b0;
    end
    got = 64'd0;
    for (int j = 0; j < 8; j++) begin
      if (line_v[j*10] !== 1'b0 || line_v[j*10+9] !== 1'b1) ok = 1'b0;
      for (int bb = 0; bb < 8; bb++) b[bb] = line_v[j*10+1+bb];
      got = {got[55:0], b};
    end
    chk({name, " framing"}, 64'(ok), 64'd1);
    chk({name, " bytes"}, got, exp_bytes);
    chk({name, " byte0 line"}, 64'(line_v[0:9]), 64'(exp_line0));
  endtask

  initial begin
    logic flag;
    cv[0]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[2]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[3]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[5]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[6]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[7]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[8]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[9]  = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[10] = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[11] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[12] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};

    fv[0] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 10'b0100000001};
    fv[1] = '{64'hA55A00FF80017E3C, 64'hA55A00FF80017E3C, 10'b0101001011};
    fv[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 10'b0111111111};
    fv[3] = '{64'h0000000000000000, 64'h0000000000000000, 10'b0000000001};

    rst = 1'b1;
    uart_start = 2'b00;
    rx_data = 64'h0123456789ABCDEF;
    tick();

    for (int i = 0; i < 13; i++) begin
      rst = cv[i].rst;
      uart_start = cv[i].start;
      tick();
      chk($sformatf("vec%0d tx/busy/done/ov", i),
          64'({uart_tx, busy, done, overrun}),
          64'({cv[i].exp_tx, cv[i].exp_busy, cv[i].exp_done, cv[i].exp_ov}));
    end

    for (int i = 0; i < 4; i++) begin
      rx_data = fv[i].data;
      uart_start = 2'b01;
      tick();
      uart_start = 2'b00;
      rx_data = ~fv[i].data;
      run_frame($sformatf("frame%0d", i), fv[i].exp_bytes, fv[i].exp_line0, -1, -1, 1'b0);
      tick();
      chk($sformatf("frame%0d after done", i), 64'({uart_tx, busy, done}), 64'b100);
    end

    // Level held for ~100 cycles must give exactly one frame
    rx_data = 64'h0123456789ABCDEF;
    uart_start = 2'b01;
    tick();
    run_frame("held", 64'h0123456789ABCDEF, 10'b0100000001, 98, -1, 1'b0);
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy || done || !uart_tx) flag = 1'b1;
    end
    chk("held no second frame", 64'(flag), 64'd0);

    // Second request during byte 2, then back-to-back trigger in the done cycle
    rx_data = 64'h0123456789ABCDEF;
    uart_start = 2'b01;
    tick();
    uart_start = 2'b00;
    run_frame("overrun", 64'h0123456789ABCDEF, 10'b0100000001, -1, 90, 1'b1);
    rx_data = 64'h1122334455667788;
    uart_start = 2'b01;
    tick();
    uart_start = 2'b00;
    chk("b2b start bit", 64'({uart_tx, busy}), 64'b01);
    run_frame("b2b", 64'h1122334455667788, 10'b0100010001, -1, -1, 1'b0);
    tick();

    // Reset during byte 3 aborts the frame without done
    rx_data = 64'h0123456789ABCDEF;
    uart_start = 2'b01;
    tick();
    uart_start = 2'b00;
    repeat (130) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset tx/busy/done", 64'({uart_tx, busy, done}), 64'b100);
    flag = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (busy || done || !uart_tx) flag = 1'b1;
    end
    chk("midreset stays idle", 64'(flag), 64'd0);
    rx_data = 64'hA55A00FF80017E3C;
    uart_start = 2'b01;
    tick();
    uart_start = 2'b00;
    run_frame("after reset", 64'hA55A00FF80017E3C, 10'b0101001011, -1, -1, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
